// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares a single async_transmitter between NREQ byte requesters using
// round-robin arbitration. It sequences the transmitter's start/busy
// handshake and holds the granted byte on TxD_data for the whole frame.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   req          per-requester send request (level)
//   req_data     byte of requester i in bits [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse, byte of requester i accepted
//   TxD_start    one-cycle start pulse to the transmitter
//   TxD_data     byte to the transmitter, held from grant until IDLE
//   TxD_busy     transmitter busy
//   active_id    index of the current or last grant
//   sending      high whenever the arbiter is not IDLE
//   frames_sent  count of completed frames (wraps)
//   err          one-cycle WAIT_HI timeout pulse
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a watchdog that abandons
// a frame if the transmitter never raises busy within BUSY_WAIT cycles.
// Without it, WAIT_HI waits indefinitely and err is tied low.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int DATA_W    = 8,
   parameter int BUSY_WAIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          ack,
   output logic                     TxD_start,
   output logic [DATA_W-1:0]        TxD_data,
   input  logic                     TxD_busy,
   output logic [$clog2(NREQ)-1:0]  active_id,
   output logic                     sending,
   output logic [15:0]              frames_sent,
   output logic                     err
);

   localparam int ID_W = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [15:0]         frames_q, frames_d;

   logic                grant;
   logic                timeout;
   logic [ID_W-1:0]     winner;
   logic [DATA_W-1:0]   req_bytes [NREQ];

   // Round-robin search: first requester after the pointer, wrapping.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [ID_W-1:0] ptr);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && r[ID_W'(idx)]) begin
            pick  = ID_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
   end

   assign winner = rr_pick(req, last_q);
   assign grant  = (|req) && !TxD_busy;

`ifdef UART_ARB_TIMEOUT_EN
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;

   // wd_q holds the number of WAIT_HI cycles already completed.
   assign timeout = (state_q == WAIT_HI) && !TxD_busy && (wd_q == 8'(BUSY_WAIT - 1));

   always_comb begin
      wd_d  = wd_q;
      err_d = timeout;
      if (state_q == LAUNCH) begin
         wd_d = 8'd0;
      end else if (state_q == WAIT_HI) begin
         wd_d = wd_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= 8'd0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= ID_W'(NREQ - 1);
         id_q     <= '0;
         data_q   <= '0;
         frames_q <= 16'd0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         data_q   <= data_d;
         frames_q <= frames_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = LAUNCH;
         LAUNCH:  state_d = WAIT_HI;
         WAIT_HI: begin
            if (TxD_busy)     state_d = WAIT_LO;
            else if (timeout) state_d = IDLE;
         end
         WAIT_LO: if (!TxD_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: the byte is latched only on the grant edge.
   always_comb begin
      last_d   = last_q;
      id_d     = id_q;
      data_d   = data_q;
      frames_d = frames_q;
      if (state_q == IDLE && grant) begin
         id_d   = winner;
         data_d = req_bytes[winner];
      end
      if (state_q == WAIT_LO && !TxD_busy) begin
         last_d   = id_q;
         frames_d = frames_q + 16'd1;
      end
      if (timeout) begin
         last_d = id_q;
      end
   end

   // Outputs: ack and TxD_start share the LAUNCH cycle.
   always_comb begin
      TxD_start   = (state_q == LAUNCH);
      ack         = TxD_start ? ({{(NREQ-1){1'b0}}, 1'b1} << id_q) : '0;
      sending     = (state_q != IDLE);
      TxD_data    = data_q;
      active_id   = id_q;
      frames_sent = frames_q;
   end

endmodule
